// File: rtl/instr_fetch.sv
// Instruction fetch stage: variable-latency I-cache handshake, output register
// plus one-entry skid buffer, and jump redirect with in-flight response drain.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freezeID,
   input  logic        jFlag,
   input  logic [31:0] PC_target,
   output logic        icReq,
   output logic [31:0] icAddr,
   input  logic        icAck,
   input  logic [31:0] icData,
   output logic [31:0] instr,
   output logic [31:0] PC_out,
   output logic        done_out
);

   localparam int unsigned W = 32;

   typedef enum logic [1:0] {IDLE, REQ, FULL, DRAIN} state_t;

   typedef struct packed {
      logic [W-1:0] word;
      logic [W-1:0] pc4;
   } entry_t;

   state_t         state, state_n;
   logic           started;
   logic [W-1:0]   pc, pc_n, addr_n;
   entry_t         out_q, out_n, sk, sk_n, fetched;
   logic           sk_v, sk_v_n, done_n, req_n;
   logic           consume, redir, accept;

   assign instr  = out_q.word;
   assign PC_out = out_q.pc4;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Data routing, fetch PC and FSM next-state
   always_comb begin
      state_n = state;
      pc_n    = pc;
      out_n   = out_q;
      done_n  = done_out;
      sk_n    = sk;
      sk_v_n  = sk_v;
      consume = done_out & ~freezeID;
      redir   = consume & jFlag;
      accept  = (state == REQ) & icReq & icAck;
      fetched = '{word: icData, pc4: pc + W'(4)};

      if (accept) pc_n = pc + W'(4);

      if (redir) begin
         pc_n   = PC_target;
         done_n = 1'b0;
         sk_v_n = 1'b0;
      end else if (accept) begin
         if ((!done_out || consume) && !sk_v) begin
            out_n  = fetched;
            done_n = 1'b1;
         end else if (consume) begin
            out_n = sk;
            sk_n  = fetched;
         end else begin
            sk_n   = fetched;
            sk_v_n = 1'b1;
         end
      end else if (consume) begin
         if (sk_v) begin
            out_n  = sk;
            sk_v_n = 1'b0;
         end else begin
            done_n = 1'b0;
         end
      end

      case (state)
         IDLE:    if (started) state_n = REQ;
         REQ: begin
            if (redir && !accept) state_n = DRAIN;
            else if (sk_v_n)      state_n = FULL;
         end
         FULL:    if (!sk_v_n) state_n = REQ;
         DRAIN:   if (icAck) state_n = REQ;
         default: state_n = IDLE;
      endcase

      // A draining request keeps its original address until acknowledged
      req_n  = (state_n == REQ) || (state_n == DRAIN);
      addr_n = (state_n == DRAIN) ? icAddr : pc_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         started  <= 1'b0;
         pc       <= RESET_PC;
         icReq    <= 1'b0;
         icAddr   <= RESET_PC;
         out_q    <= '0;
         done_out <= 1'b0;
         sk       <= '0;
         sk_v     <= 1'b0;
      end else begin
         started  <= 1'b1;
         pc       <= pc_n;
         icReq    <= req_n;
         icAddr   <= addr_n;
         out_q    <= out_n;
         done_out <= done_n;
         sk       <= sk_n;
         sk_v     <= sk_v_n;
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: cache responder with programmable latency, a queue-based
// reference model compared every cycle, and directed literal checks.
module tb_instr_fetch;

   localparam logic [31:0] RPC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freezeID, jFlag, icAck, icReq, done_out;
   logic [31:0] PC_target, icData, icAddr, instr, PC_out;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .freezeID(freezeID), .jFlag(jFlag),
      .PC_target(PC_target), .icReq(icReq), .icAddr(icAddr), .icAck(icAck),
      .icData(icData), .instr(instr), .PC_out(PC_out), .done_out(done_out)
   );

   int errors = 0;
   int checks = 0;
   int lat = 1;
   int cnt = 0;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc4;
   } ent_t;

   ent_t        q[$];
   bit          m_started, m_req, m_drain;
   logic [31:0] m_pc, m_addr;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h2001_0005 + (a - RPC);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_started = 0;
      m_req     = 0;
      m_drain   = 0;
      m_pc      = RPC;
      m_addr    = RPC;
   endtask

   // Up to two fetched words in program order; keep requesting while room remains
   task automatic model_step();
      bit   consume, redir, accept, was_drain;
      ent_t e;
      consume   = (q.size() > 0) && !freezeID;
      redir     = consume && jFlag;
      accept    = m_req && !m_drain && icAck;
      was_drain = m_drain;
      if (consume) void'(q.pop_front());
      if (redir) begin
         q.delete();
         m_pc = PC_target;
      end else if (accept) begin
         e.word = mem(m_pc);
         e.pc4  = m_pc + 32'd4;
         q.push_back(e);
         m_pc = m_pc + 32'd4;
      end
      if (was_drain)                      m_drain = !icAck;
      else if (redir && m_req && !accept) m_drain = 1;
      if (m_drain) m_req = 1;
      else begin
         m_req  = m_started && (q.size() < 2);
         m_addr = m_pc;
      end
      m_started = 1;
   endtask

   always @(posedge clk) if (rst === 1'b1) model_step();
   always @(negedge rst) model_reset();

   // Cache: acknowledge in the lat-th cycle of each request
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         icAck = 0;
         cnt   = 0;
      end else begin
         if (icAck) cnt = 0;
         if (icReq !== 1'b1) begin
            cnt   = 0;
            icAck = 0;
         end else begin
            cnt++;
            icAck  = (cnt >= lat);
            icData = icAck ? mem(icAddr) : 32'h0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         chk("m_icReq", 32'(icReq), 32'(m_req));
         chk("m_done", 32'(done_out), 32'(q.size() > 0));
         if (m_req) chk("m_icAddr", icAddr, m_addr);
         if (q.size() > 0) begin
            chk("m_instr", instr, q[0].word);
            chk("m_PC_out", PC_out, q[0].pc4);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic bit cond(input int kind, input logic [31:0] v);
      case (kind)
         0:       return done_out === 1'b1;
         1:       return icReq === 1'b0;
         2:       return icReq === 1'b1 && icAddr === v;
         3:       return done_out === 1'b1 && icReq === 1'b1 && icAck === 1'b0;
         4:       return icReq === 1'b1;
         default: return 0;
      endcase
   endfunction

   task automatic wait_cond(input string name, input int kind, input logic [31:0] v);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!cond(kind, v) && n < 40);
      if (!cond(kind, v)) begin
         checks++;
         errors++;
         $display("FAIL timeout %s: condition not reached after %0d cycles", name, n);
      end
   endtask

   initial begin
      freezeID  = 1;
      jFlag     = 0;
      PC_target = 32'h0;
      icAck     = 0;
      icData    = 32'h0;
      lat       = 2;
      model_reset();
      tick();
      chk("rst_icReq", 32'(icReq), 0);
      chk("rst_done", 32'(done_out), 0);
      chk("rst_icAddr", icAddr, 32'h0040_0000);
      chk("rst_instr", instr, 0);
      chk("rst_PC_out", PC_out, 0);
      rst = 1;

      wait_cond("first_req", 4, 0);
      chk("first_icAddr", icAddr, 32'h0040_0000);
      wait_cond("first_done", 0, 0);
      chk("first_instr", instr, 32'h2001_0005);
      chk("first_PC_out", PC_out, 32'h0040_0004);
      chk("first_done", 32'(done_out), 1);
      wait_cond("skid_full", 1, 0);
      chk("held_instr", instr, 32'h2001_0005);
      chk("skid_valid", 32'(dut.sk_v), 1);

      lat = 1;
      freezeID = 0;
      repeat (6) tick();
      freezeID = 1;
      repeat (3) tick();
      chk("freeze_icReq", 32'(icReq), 0);
      chk("freeze_done", 32'(done_out), 1);
      freezeID = 0;
      repeat (4) tick();

      #2 rst = 0;
      #1;
      chk("async_icReq", 32'(icReq), 0);
      chk("async_done", 32'(done_out), 0);
      chk("async_sk_v", 32'(dut.sk_v), 0);
      tick();
      rst = 1;
      wait_cond("restart_req", 4, 0);
      chk("restart_icAddr", icAddr, RPC);

      wait_cond("addr8", 2, 32'h0040_0008);
      chk("prejump_instr", instr, 32'h2001_0009);
      jFlag = 1;
      PC_target = 32'h0040_0040;
      tick();
      jFlag = 0;
      chk("jack_done", 32'(done_out), 0);
      chk("jack_icAddr", icAddr, 32'h0040_0040);
      tick();
      chk("jack_instr", instr, 32'h2001_0045);
      chk("jack_PC_out", PC_out, 32'h0040_0044);

      lat = 4;
      wait_cond("outstanding", 3, 0);
      jFlag = 1;
      PC_target = 32'h0040_0100;
      tick();
      jFlag = 0;
      chk("drain_done", 32'(done_out), 0);
      chk("drain_icReq", 32'(icReq), 1);
      chk("drain_icAddr", icAddr, 32'h0040_0048);
      wait_cond("drain_exit", 2, 32'h0040_0100);
      wait_cond("drain_target", 0, 0);
      chk("drain_instr", instr, 32'h2001_0105);
      chk("drain_PC_out", PC_out, 32'h0040_0104);

      freezeID = 1;
      lat = 1;
      wait_cond("skid_full2", 1, 0);
      freezeID = 0;
      jFlag = 1;
      PC_target = 32'h0040_0200;
      tick();
      jFlag = 0;
      chk("fullredir_done", 32'(done_out), 0);
      chk("fullredir_icAddr", icAddr, 32'h0040_0200);
      chk("fullredir_sk_v", 32'(dut.sk_v), 0);
      tick();
      chk("fullredir_instr", instr, 32'h2001_0205);
      chk("fullredir_PC_out", PC_out, 32'h0040_0204);
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 32-bit MIPS pipeline. Drives the decode stage with `instr`, the instruction's PC+4 and a `done` valid flag. Consumes the decode stage's freeze, jump-flag and jump-target signals to redirect fetch. Talks to the instruction cache through a variable-latency request/acknowledge handshake and buffers one extra instruction so the cache is not stalled by a single-cycle freeze.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `freezeID`  in  1  decode stall; the output instruction is not consumed this cycle.
- `jFlag`  in  1  decode reports a j/jr in the currently presented `instr`.
- `PC_target`  in  32  redirect target from decode, valid when `jFlag`=1.
- `icReq`  out  1  cache request valid.
- `icAddr`  out  32  cache word address.
- `icAck`  in  1  cache response valid; completes the outstanding request.
- `icData`  in  32  instruction word, valid with `icAck`.
- `instr`  out  32  instruction presented to decode.
- `PC_out`  out  32  PC+4 of the presented instruction; feeds decode `PC_in`.
- `done_out`  out  1  `instr`/`PC_out` are valid.

## Operation
- Internal state: fetch PC `pc`, output register (`instr`, `PC_out`, `done_out`), one-entry skid buffer (`sk_instr`, `sk_pc4`, `sk_v`), and an FSM with states `IDLE`, `REQ`, `FULL`, `DRAIN`.
- Consume: `consume` = `done_out` & !`freezeID`, sampled at the clock edge.
- Redirect: `redir` = `consume` & `jFlag`. `jFlag` is ignored unless `consume` is true, so a held jump redirects exactly once.
- Accept: a response is accepted when `icReq`=1 and `icAck`=1. Accepted data is tagged with `pc` as the fetch address and `pc`+4 as its PC+4. After acceptance, `pc` becomes `pc`+4. All arithmetic is modulo 2^32.
- Routing of accepted data, in priority order:
  - If `redir`: the data is discarded, `pc` is set to `PC_target`, and the skid buffer is cleared.
  - Else, if the output register is empty or consumed this cycle, and `sk_v`=0: the data is loaded into the output register.
  - Else, if the output register is consumed and `sk_v`=1: the skid entry moves to the output register and the data goes into the skid buffer.
  - Else, the data goes into the skid buffer.
- When the output register is consumed and no data is loaded, the skid entry moves to the output register if `sk_v`=1. Otherwise `done_out` is set to 0.
- FSM:
  - `IDLE`: the first cycle after reset release, with `icReq`=0. Next state is `REQ`.
  - `REQ`: `icReq`=1 and `icAddr`=`pc`; both are held stable until `icAck`.
    - Redirect without ack: go to `DRAIN`.
    - Skid becomes full: go to `FULL`.
    - Otherwise stay in `REQ`, issuing back-to-back requests with no idle cycle between them.
  - `FULL`: `icReq`=0. Stay while `sk_v`=1. Go to `REQ` once the skid buffer empties, either by consume or by redirect; a redirect sets `pc` to `PC_target`.
  - `DRAIN`: `icReq` stays 1 with `icAddr` at the old address until `icAck`. The response is discarded and `pc` keeps `PC_target`. Next state is `REQ`.
  - A redirect during `DRAIN` overwrites `pc` again.
- `icAck` outside `REQ`/`DRAIN` is ignored.
- No branch-delay slot: the fall-through instruction after a consumed jump is never presented.

## Timing
- Reset values while `rst`=0, applied immediately and asynchronously:
  - state `IDLE`, `pc`=`RESET_PC`
  - `icReq`=0, `icAddr`=`RESET_PC`
  - `instr`=0, `PC_out`=0, `done_out`=0, `sk_v`=0
- First `icReq` goes high on the 2nd rising edge after `rst` deasserts.
- Latency: if `icAck` arrives in cycle N, `done_out`/`instr` are valid from cycle N+1. The minimum cache round trip is 1 cycle, which gives a throughput of 1 instruction per cycle.
- Redirect: with `redir` at edge E and no request outstanding, `icAddr`=`PC_target` in cycle E+1. With a request outstanding, the address changes the cycle after the draining `icAck`.
- `instr`, `PC_out` and `done_out` hold unchanged while `freezeID`=1.
- At most 2 instructions are buffered (output register + skid). No overflow is possible because the FSM leaves `REQ` when the skid fills.
- Simultaneous consume and ack with the skid full: the skid shifts to the output and the new data enters the skid, preserving order.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000 and `icAck` 2 cycles after each request, `icData`=32'h2001_0005 → `icAddr`=32'h0040_0000, then `instr`=32'h2001_0005, `PC_out`=32'h0040_0004, `done_out`=1.
- Single-cycle acks with `freezeID`=1 for 3 cycles → output held, skid filled, `icReq` drops to 0. On release, instructions appear in address order with no loss or duplication.
- Consume j (`jFlag`=1, `PC_target`=32'h0040_0040) while the ack for 32'h0040_0008 arrives the same cycle → that data is discarded and the next `icAddr`=32'h0040_0040.
- Redirect while a request is outstanding and `icAck` arrives 3 cycles later → `DRAIN` is entered, that response is discarded, and `icAddr`=target in the following cycle.
- Redirect while the skid buffer is full → skid cleared, next presented instruction comes from the target.
- Assert `rst` low mid-request, between clock edges → `icReq`, `done_out` and `sk_v` go to 0 immediately. After release, fetch restarts at `RESET_PC`.
